// File: rtl/stopwatch_pkg.sv
// Shared state encoding and sizing helpers for the stopwatch control slice.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } sw_state_t;

    function automatic int unsigned ctr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned tick_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic int unsigned presc_width(input int unsigned clk_hz,
                                                input int unsigned tick_hz);
        return ctr_width(tick_div(clk_hz, tick_hz));
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-count debounce and a
// single-cycle press pulse on the accepted level's rising transition.
module sw_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned    CW   = ctr_width(DB_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            press <= 1'b0;
            // Any sample that agrees with the accepted level restarts the count.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= sync2;
                press <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing: button conditioning, IDLE/RUN/PAUSE FSM, tick prescaler.
// Optional lap-hold feature enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned TICK_HZ   = 100,
    parameter int unsigned DB_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button_start,
    input  logic       button_stop,
    input  logic       button_reset,
`ifdef STOPWATCH_LAP_EN
    input  logic       button_lap,
    output logic       lap_hold,
`endif
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       running,
    output logic [1:0] state
);

    localparam int unsigned   DIV  = tick_div(CLK_HZ, TICK_HZ);
    localparam int unsigned   PW   = presc_width(CLK_HZ, TICK_HZ);
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    logic press_start;
    logic press_stop;
    logic press_reset;

    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (button_start),
        .press   (press_start)
    );

    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_stop (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (button_stop),
        .press   (press_stop)
    );

    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_reset (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (button_reset),
        .press   (press_reset)
    );

`ifdef STOPWATCH_LAP_EN
    logic press_lap;
    logic lap_d;

    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (button_lap),
        .press   (press_lap)
    );
`endif

    sw_state_t     state_q;
    sw_state_t     state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          en_d;
    logic          clr_d;
    logic          clr_pending;
    logic          run_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            cnt_en      <= 1'b0;
            cnt_clr     <= 1'b0;
            running     <= 1'b0;
            clr_pending <= 1'b1;
`ifdef STOPWATCH_LAP_EN
            lap_hold    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            cnt_en      <= en_d;
            cnt_clr     <= clr_d | clr_pending;
            running     <= (state_d == ST_RUN);
            clr_pending <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_hold    <= lap_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap_d   = lap_hold;
`endif
        // Priority reset > stop > start (> lap); a higher press that is
        // ignored in the current state still masks the lower ones.
        if (press_reset) begin
            state_d = ST_IDLE;
            clr_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!press_stop && press_start) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (press_stop) begin
                        state_d = ST_PAUSE;
                    end
`ifdef STOPWATCH_LAP_EN
                    else if (!press_start && press_lap) begin
                        lap_d = ~lap_hold;
                    end
`endif
                end
                ST_PAUSE: begin
                    if (!press_stop && press_start) state_d = ST_RUN;
                end
                default: state_d = ST_IDLE;
            endcase
        end
`ifdef STOPWATCH_LAP_EN
        if (state_d == ST_IDLE) lap_d = 1'b0;
`endif
    end

    // Ticks only while RUN persists across the edge, so cnt_en never lands in
    // a cycle whose visible state is PAUSE/IDLE or coincides with cnt_clr.
    always_comb begin
        run_now = (state_q == ST_RUN) && (state_d == ST_RUN);
        presc_d = presc_q;
        en_d    = 1'b0;
        if (run_now) begin
            if (presc_q == PMAX) begin
                presc_d = '0;
                en_d    = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end else if (state_d == ST_IDLE) begin
            presc_d = '0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: expected events queued with stimulus.
module tb_stopwatch_ctrl;

    logic       clk          = 1'b0;
    logic       rst          = 1'b1;
    logic       button_start = 1'b0;
    logic       button_stop  = 1'b0;
    logic       button_reset = 1'b0;
    logic       cnt_en;
    logic       cnt_clr;
    logic       running;
    logic [1:0] state;
`ifdef STOPWATCH_LAP_EN
    logic       button_lap   = 1'b0;
    logic       lap_hold;
`endif

    stopwatch_ctrl #(
        .CLK_HZ    (1000),
        .TICK_HZ   (100),
        .DB_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .button_start (button_start),
        .button_stop  (button_stop),
        .button_reset (button_reset),
`ifdef STOPWATCH_LAP_EN
        .button_lap   (button_lap),
        .lap_hold     (lap_hold),
`endif
        .cnt_en       (cnt_en),
        .cnt_clr      (cnt_clr),
        .running      (running),
        .state        (state)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    typedef struct {
        int         at;
        logic [1:0] val;
    } st_exp_t;

    st_exp_t exp_state[$];
    int      exp_tick[$];
    int      exp_clr[$];
    st_exp_t e_mon;
    int      checks = 0;
    int      errors = 0;
    logic    mon_en = 1'b0;
    logic [1:0] prev_state = 2'b00;

    task automatic check(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_state(input int at, input logic [1:0] val);
        st_exp_t e;
        e.at  = at;
        e.val = val;
        exp_state.push_back(e);
    endtask

    task automatic push_ticks(input int first, input int last);
        for (int t = first; t <= last; t += 10) exp_tick.push_back(t);
    endtask

    // Monitor: every DUT event pops its scoreboard entry.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (state != prev_state) begin
                check("running_tracks_state", int'(running), int'(state == 2'b01));
                if (exp_state.size() == 0) begin
                    check("state_change_unexpected", cyc, -1);
                end else begin
                    e_mon = exp_state.pop_front();
                    check("state_cycle", cyc, e_mon.at);
                    check("state_value", int'(state), int'(e_mon.val));
                end
                prev_state = state;
            end
            if (cnt_en) begin
                check("tick_only_in_run", int'(state), 1);
                check("tick_not_with_clr", int'(cnt_clr), 0);
                if (exp_tick.size() == 0) check("tick_unexpected", cyc, -1);
                else check("tick_cycle", cyc, exp_tick.pop_front());
            end
            if (cnt_clr) begin
                if (exp_clr.size() == 0) check("clr_unexpected", cyc, -1);
                else check("clr_cycle", cyc, exp_clr.pop_front());
            end
        end
    end

    int n, r, s, b, c, d, e, f, g;

    initial begin
        // 1. reset then idle
        step(3);
        rst = 1'b0;
        exp_clr.push_back(cyc + 1);
        mon_en = 1'b1;
        step(1);
        check("reset_state", int'(state), 0);
        check("reset_running", int'(running), 0);
        check("reset_cnt_en", int'(cnt_en), 0);
`ifdef STOPWATCH_LAP_EN
        check("reset_lap_hold", int'(lap_hold), 0);
`endif
        step(100);
        check("idle_state", int'(state), 0);
        check("idle_clr_left", exp_clr.size(), 0);

        // 2. start and count
        n = cyc;
        button_start = 1'b1;
        r = n + 7;
        push_state(r, 2'b01);
        push_ticks(r + 10, r + 60);
        step(10);
        button_start = 1'b0;
`ifdef STOPWATCH_LAP_EN
        wait_until(r + 15);
        button_lap = 1'b1;
        step(10);
        button_lap = 1'b0;
        wait_until(r + 23);
        check("lap_set_in_run", int'(lap_hold), 1);
`endif
        wait_until(r + 52);
        check("five_ticks_seen", exp_tick.size(), 1);

        // 3. stop with prescaler=6, then resume
        wait_until(r + 60);
        button_stop = 1'b1;
        push_state(r + 67, 2'b10);
        step(10);
        button_stop = 1'b0;
        wait_until(r + 90);
        check("paused_state", int'(state), 2);
        check("pause_no_tick", exp_tick.size(), 0);

        s = cyc;
        button_start = 1'b1;
        push_state(s + 7, 2'b01);
        push_ticks(s + 11, s + 41);
        step(10);
        button_start = 1'b0;
        wait_until(s + 40);
        button_stop = 1'b1;
        push_state(s + 47, 2'b10);
        step(10);
        button_stop = 1'b0;
        wait_until(s + 60);
        check("resume_ticks_done", exp_tick.size(), 0);

        // 4. bounce rejection from PAUSE
        b = cyc;
        for (int i = 0; i < 10; i++) begin
            button_start = (i % 2 == 0);
            step(2);
        end
        button_start = 1'b1;
        push_state(b + 27, 2'b01);
        push_ticks(b + 32, b + 52);
        wait_until(b + 26);
        check("bounce_no_early_change", int'(state), 2);
        wait_until(b + 32);
        button_start = 1'b0;

        // 5. simultaneous presses
        wait_until(b + 50);
        c = cyc;
        button_start = 1'b1;
        button_stop  = 1'b1;
        button_reset = 1'b1;
        push_state(c + 7, 2'b00);
        exp_clr.push_back(c + 7);
        step(12);
        button_start = 1'b0;
        button_stop  = 1'b0;
        button_reset = 1'b0;
        wait_until(c + 20);
        check("all_press_idle", int'(state), 0);
`ifdef STOPWATCH_LAP_EN
        check("lap_cleared_idle", int'(lap_hold), 0);
`endif

        d = cyc;
        button_start = 1'b1;
        push_state(d + 7, 2'b01);
        push_ticks(d + 17, d + 17);
        step(10);
        button_start = 1'b0;
        wait_until(d + 20);
        button_stop = 1'b1;
        push_state(d + 27, 2'b10);
        step(10);
        button_stop = 1'b0;
        wait_until(d + 40);
        e = cyc;
        button_start = 1'b1;
        button_stop  = 1'b1;
        step(10);
        button_start = 1'b0;
        button_stop  = 1'b0;
        wait_until(e + 25);
        check("start_stop_in_pause", int'(state), 2);

        // 6. rst mid-RUN (resumes with prescaler at 9, so first tick is next cycle)
        f = cyc;
        button_start = 1'b1;
        push_state(f + 7, 2'b01);
        push_ticks(f + 8, f + 8);
        step(10);
        button_start = 1'b0;
        wait_until(f + 13);
        rst = 1'b1;
        push_state(f + 14, 2'b00);
        step(1);
        rst = 1'b0;
        exp_clr.push_back(f + 15);
        check("rst_run_state", int'(state), 0);
        check("rst_run_running", int'(running), 0);
        check("rst_run_cnt_en", int'(cnt_en), 0);
`ifdef STOPWATCH_LAP_EN
        check("rst_run_lap_hold", int'(lap_hold), 0);
`endif
        wait_until(f + 25);
        g = cyc;
        button_start = 1'b1;
        push_state(g + 7, 2'b01);
        push_ticks(g + 17, g + 27);
        step(10);
        button_start = 1'b0;
        wait_until(g + 30);

        check("state_events_left", exp_state.size(), 0);
        check("tick_events_left", exp_tick.size(), 0);
        check("clr_events_left", exp_clr.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
